// File: rtl/dct8_butterfly_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dct8_pkg: widths, butterfly schedule and coefficient ROM for the 8-point DCT sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dct8_pkg;

  localparam int DCT8_W        = 18;
  localparam int DCT8_CW       = 17;
  localparam int NUM_OPS       = 12;
  localparam int OPS_PER_STAGE = 4;

  typedef struct packed {
    logic [2:0]         src_a;
    logic [2:0]         src_b;
    logic [DCT8_CW-1:0] coeff;
  } op_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  // Q.8 unsigned coefficients, one per butterfly op in issue order
  localparam logic [DCT8_CW-1:0] DCT8_COEFF [NUM_OPS] = '{
    17'd256, 17'd256, 17'd256, 17'd256,
    17'd256, 17'd256, 17'd362, 17'd362,
    17'd181, 17'd334, 17'd139, 17'd50
  };

  localparam op_t DCT8_SCHED [NUM_OPS] = '{
    '{3'd0, 3'd7, DCT8_COEFF[0]},  '{3'd1, 3'd6, DCT8_COEFF[1]},
    '{3'd2, 3'd5, DCT8_COEFF[2]},  '{3'd3, 3'd4, DCT8_COEFF[3]},
    '{3'd0, 3'd3, DCT8_COEFF[4]},  '{3'd1, 3'd2, DCT8_COEFF[5]},
    '{3'd4, 3'd7, DCT8_COEFF[6]},  '{3'd5, 3'd6, DCT8_COEFF[7]},
    '{3'd0, 3'd1, DCT8_COEFF[8]},  '{3'd2, 3'd3, DCT8_COEFF[9]},
    '{3'd4, 3'd5, DCT8_COEFF[10]}, '{3'd6, 3'd7, DCT8_COEFF[11]}
  };

endpackage

`default_nettype wire

// File: rtl/dct8_butterfly_sequencer_if.sv
// ---------------------------------------------------------------------------
// dct8_butterfly_sequencer_if: sample in, butterfly issue/return, result out. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dct8_butterfly_sequencer_if
  import dct8_pkg::*;
#(
  parameter int W  = DCT8_W,
  parameter int CW = DCT8_CW
);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          bf_valid;
  logic [W-1:0]  bf_top;
  logic [W-1:0]  bf_bot;
  logic [CW-1:0] bf_coeff;
  logic [W-1:0]  bf_top_res;
  logic [W-1:0]  bf_bot_res;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;

  modport master (
    input  in_valid, in_data, bf_top_res, bf_bot_res, out_ready,
    output in_ready, bf_valid, bf_top, bf_bot, bf_coeff, out_valid, out_data, busy, done
  );

  modport slave (
    output in_valid, in_data, bf_top_res, bf_bot_res, out_ready,
    input  in_ready, bf_valid, bf_top, bf_bot, bf_coeff, out_valid, out_data, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/dct8_butterfly_sequencer_wb_pipe.sv
// ---------------------------------------------------------------------------
// dct8_wb_pipe: BF_LAT-deep delay line of {valid, dst_a, dst_b} for in-place writeback. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dct8_wb_pipe #(
  parameter int BF_LAT = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       issue,
  input  wire logic [2:0] issue_a,
  input  wire logic [2:0] issue_b,
  output logic            wb_valid,
  output logic [2:0]      wb_a,
  output logic [2:0]      wb_b
);

  typedef struct packed {
    logic       v;
    logic [2:0] a;
    logic [2:0] b;
  } slot_t;

  slot_t pipe [BF_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{issue, issue_a, issue_b};
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign wb_valid = pipe[BF_LAT-1].v;
  assign wb_a     = pipe[BF_LAT-1].a;
  assign wb_b     = pipe[BF_LAT-1].b;

endmodule

`default_nettype wire

// File: rtl/dct8_butterfly_sequencer.sv
// ---------------------------------------------------------------------------
// dct8_butterfly_sequencer: loads 8 samples, runs the 12-op DCT butterfly schedule in place, streams results. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dct8_butterfly_sequencer
  import dct8_pkg::*;
#(
  parameter int W      = DCT8_W,
  parameter int CW     = DCT8_CW,
  parameter int BF_LAT = 1
) (
  input wire logic                     clk,
  input wire logic                     reset,
  dct8_butterfly_sequencer_if.master   bus
);

  state_t       state, state_nx;
  logic [2:0]   wr_cnt, rd_cnt;
  logic [3:0]   op_idx;
  logic [1:0]   bub_cnt;
  logic [W-1:0] buffer [8];
  op_t          op;
  logic         accept, issue, out_fire, last_out, bub_last, to_out;
  logic         wb_valid;
  logic [2:0]   wb_a, wb_b, rd_idx;
  logic [W-1:0] rd_word;

  assign op       = DCT8_SCHED[op_idx];
  assign accept   = bus.in_valid & bus.in_ready;
  assign issue    = (state == ST_RUN);
  assign out_fire = bus.out_valid & bus.out_ready;
  assign last_out = out_fire & (rd_cnt == 3'd7);
  assign bub_last = (bub_cnt == 2'(BF_LAT - 1));
  assign to_out   = (state == ST_BUBBLE) & bub_last & (op_idx == 4'(NUM_OPS));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:   if (accept && wr_cnt == 3'd7) state_nx = ST_RUN;
      ST_RUN:    if (op_idx[1:0] == 2'(OPS_PER_STAGE - 1)) state_nx = ST_BUBBLE;
      ST_BUBBLE: if (bub_last) state_nx = (op_idx == 4'(NUM_OPS)) ? ST_OUT : ST_RUN;
      ST_OUT:    if (last_out) state_nx = ST_LOAD;
      default:   state_nx = ST_LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.bf_valid = 1'b0;
    bus.bf_top   = '0;
    bus.bf_bot   = '0;
    bus.bf_coeff = '0;
    bus.busy     = 1'b0;
    bus.done     = last_out;
    if (!reset) begin
      case (state)
        ST_LOAD: bus.in_ready = 1'b1;
        ST_RUN: begin
          bus.bf_valid = 1'b1;
          bus.bf_top   = buffer[op.src_a];
          bus.bf_bot   = buffer[op.src_b];
          bus.bf_coeff = CW'(op.coeff);
          bus.busy     = 1'b1;
        end
        default: bus.busy = 1'b1;
      endcase
    end
  end

  dct8_wb_pipe #(.BF_LAT(BF_LAT)) u_wb_pipe (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_a  (op.src_a),
    .issue_b  (op.src_b),
    .wb_valid (wb_valid),
    .wb_a     (wb_a),
    .wb_b     (wb_b)
  );

  // Forward a same-cycle writeback so the registered output never sees stale data
  assign rd_idx = out_fire ? (rd_cnt + 3'd1) : 3'd0;
  always_comb begin
    rd_word = buffer[rd_idx];
    if (wb_valid && wb_a == rd_idx)      rd_word = bus.bf_top_res;
    else if (wb_valid && wb_b == rd_idx) rd_word = bus.bf_bot_res;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[wr_cnt] <= bus.in_data;
    end else if (wb_valid && !reset) begin
      buffer[wb_a] <= bus.bf_top_res;
      buffer[wb_b] <= bus.bf_bot_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      op_idx        <= '0;
      bub_cnt       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (accept) wr_cnt <= wr_cnt + 3'd1;
      if (issue)  op_idx <= op_idx + 4'd1;
      if (state == ST_BUBBLE) bub_cnt <= bub_last ? 2'd0 : bub_cnt + 2'd1;
      if (to_out) begin
        op_idx        <= '0;
        bus.out_valid <= 1'b1;
        bus.out_data  <= rd_word;
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 3'd1;
        if (rd_cnt == 3'd7) begin
          bus.out_valid <= 1'b0;
          bus.out_data  <= '0;
        end else begin
          bus.out_data  <= rd_word;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dct8_butterfly_sequencer.md
Name: dct8_butterfly_sequencer

Overview:
- Sequences one shared, time-multiplexed radix-2 butterfly unit through the 3-stage, 12-operation schedule of an 8-point DCT.
- Collects 8 input samples over a valid/ready stream into a local 8-entry buffer.
- Issues butterfly operations with per-op coefficients and writes results back in place.
- Streams the 8 results out over valid/ready. Sits between the sample front-end and the coefficient post-scaler.

Parameters:
- W, 18, sample and result width (signed two's complement).
- CW, 17, coefficient width (unsigned, Q.8).
- BF_LAT, 1, butterfly latency in cycles from issue to result; legal range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer accepts a sample
- in_data  in  W  signed input sample
- bf_valid  out  1  butterfly op issued this cycle
- bf_top  out  W  top operand, buf[src_a]
- bf_bot  out  W  bottom operand, buf[src_b]
- bf_coeff  out  CW  coefficient for this op
- bf_top_res  in  W  butterfly top result, valid BF_LAT cycles after issue
- bf_bot_res  in  W  butterfly bottom result, valid BF_LAT cycles after issue
- out_valid  out  1  result sample valid
- out_ready  in  1  downstream accepts
- out_data  out  W  result sample
- busy  out  1  high in every state except LOAD
- done  out  1  one-cycle pulse when the 8th result is accepted

Behaviour:
- Reset values: in_ready=0, bf_valid=0, bf_top=0, bf_bot=0, bf_coeff=0, out_valid=0, out_data=0, busy=0, done=0. All counters = 0; state = LOAD; writeback pipe flushed. Buffer contents are don't-care.
- in_ready=1 from the first cycle after reset deassertion.
- FSM states: LOAD, RUN, BUBBLE, OUT.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes buf[wr_cnt]; wr_cnt increments 0..7.
  - The 8th accept moves to RUN next cycle; in_ready is 0 in that next cycle.
- RUN:
  - Issues op op_idx each cycle: bf_valid=1; bf_top/bf_bot/bf_coeff are driven combinationally from the buffer and the schedule ROM.
  - op_idx runs 0..11.
  - After ops 3, 7 and 11 (the last op of each stage), go to BUBBLE.
- BUBBLE:
  - bf_valid=0 for exactly BF_LAT cycles, so the stage's final writeback completes before the next stage reads.
  - Then go to RUN (next stage) or, after stage 2, to OUT.
- Writeback:
  - A BF_LAT-deep shift pipe carries {valid, dst_a, dst_b}.
  - When the pipe tail is valid: buf[dst_a] <= bf_top_res and buf[dst_b] <= bf_bot_res, in the same cycle.
  - Dst equals src (in-place operation).
- Schedule (package constants, as (a,b) pairs):
  - Stage 0: (0,7),(1,6),(2,5),(3,4).
  - Stage 1: (0,3),(1,2),(4,7),(5,6).
  - Stage 2: (0,1),(2,3),(4,5),(6,7).
  - Coefficients are taken from package table DCT8_COEFF[0..11].
- OUT:
  - out_valid=1 and out_data=buf[rd_cnt], both registered.
  - On out_valid&out_ready, rd_cnt increments.
  - When the 8th result is accepted: done=1 that cycle, then LOAD the next cycle.
  - out_data and out_valid hold stable while out_ready=0.
- Compute latency: 12 + 3*BF_LAT cycles from leaving LOAD to entering OUT (15 for BF_LAT=1).
- Timing and boundary rules:
  - No sample is accepted outside LOAD; in_valid is ignored there.
  - No output is presented outside OUT.
  - The next block's LOAD begins the cycle after done, with no overlap.
  - The sequencer does no arithmetic and no saturation; result width and wrap behaviour are owned by the butterfly.
- Reset mid-operation: all of the above reset values apply on the next edge, in-flight writebacks are discarded, and a partially loaded block is lost.

Decomposition:
- Package dct8_pkg:
  - W and CW defaults.
  - NUM_OPS=12 and OPS_PER_STAGE=4.
  - Typedef op_t {src_a[2:0], src_b[2:0], coeff[CW-1:0]}.
  - Constant DCT8_SCHED[0..11] of op_t.
  - DCT8_COEFF table.
- One natural sub-module, dct8_wb_pipe: a parameterised BF_LAT-deep valid/address delay line feeding buffer writeback.

Test Plan:
- Load samples 1..8 (buf[0]=1 .. buf[7]=8), out_ready=1, butterfly model returns (top+bot, top-bot). Checks:
  - First issue has bf_top=1, bf_bot=8, bf_coeff=DCT8_COEFF[0].
  - out_valid rises exactly 15 cycles after the 8th accept.
  - Outputs match the golden model.
- All-zero input -> 8 zero outputs, done pulses exactly once, then in_ready=1 the next cycle.
- Hold out_ready=0 for 5 cycles during OUT -> out_data stays buf[0] and out_valid stays 1; no rd_cnt advance and no done.
- BF_LAT=3 -> bf_valid low for exactly 3 cycles after ops 3, 7 and 11; stage 1 op 0 reads the stage 0 result (buf[0]=9 with the sum model).
- Assert reset during RUN at op 5 -> next cycle all outputs are at reset values and state is LOAD. A following full block of samples 1..8 produces the same results as the first scenario.
- in_valid held high throughout RUN/OUT -> in_ready=0 and no buffer corruption; results identical to the first scenario.
